layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Frame-level controller that feeds one fully-connected layer, for example the 10-neuron output layer.
- Accepts a parallel activation vector from the previous layer in a single ready/valid handshake.
- Streams the vector into the layer as numInputs back-to-back single-word beats on the layer's shared input valid/data bus.
- Blocks the next frame until the layer reports its result valid, then emits a frame-done pulse.

Parameters:
- numInputs, 30, number of activation words per frame (fan-in of the driven layer); must be >= 1.
- dataWidth, 16, width of one activation word.
- cntWidth, $clog2(numInputs+1), beat counter width (derived; not overridden).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- frame_in_valid  input  1  upstream presents a full activation vector.
- frame_in_data  input  numInputs*dataWidth  vector; word k at [k*dataWidth+:dataWidth].
- frame_in_ready  output  1  sequencer can accept a frame; combinational, equals state==IDLE.
- layer_in_valid  output  1  beat valid to the driven layer's neuron_in_valid.
- layer_in_data  output  dataWidth  beat data to the driven layer's neuron_in.
- layer_out_valid  input  1  result-valid from the driven layer (neuron 0 out valid).
- frame_done  output  1  one-cycle pulse: layer result for current frame available.
- busy  output  1  state != IDLE.
- proto_err  output  1  sticky: layer_out_valid seen outside WAIT.

Behaviour:
- Reset (async assert, sync deassert by the clock domain): state=IDLE, beat counter=0, vector buffer=0, layer_in_valid=0, layer_in_data=0, frame_done=0, proto_err=0. Outputs take these values immediately on rst_n low, including mid-frame; the partial frame is discarded.
- States: IDLE, SHIFT, WAIT.
- IDLE:
  - frame_in_ready=1.
  - If frame_in_valid at edge T: capture frame_in_data into the buffer, set counter=0, go to SHIFT.
  - Otherwise hold.
- SHIFT:
  - Cycles T+1 .. T+numInputs: layer_in_valid=1 and layer_in_data=buffer word 0..numInputs-1 in order, one word per cycle, no bubbles.
  - layer_in_data is registered.
  - The counter increments each beat. After the beat with counter==numInputs-1, go to WAIT.
  - layer_in_valid=0 from cycle T+numInputs+1.
  - numInputs=1: exactly one beat, then WAIT.
- WAIT:
  - layer_in_valid=0; layer_in_data holds its last word.
  - On layer_out_valid at edge W: frame_done=1 for the cycle after W only, and state=IDLE on that same cycle. frame_in_ready is therefore 1 in the same cycle frame_done is 1.
  - No timeout; WAIT holds until layer_out_valid.
- Handshake rules:
  - frame_in_valid is ignored while not IDLE; upstream holds the vector until ready.
  - frame_in_data is sampled only at the accepting edge; later changes have no effect on the current frame.
  - Minimum frame period is numInputs + 2 + (layer latency) cycles.
- Error rule:
  - layer_out_valid while in IDLE or SHIFT sets proto_err=1, cleared only by reset.
  - The event does not change state and does not generate frame_done.
  - Simultaneous layer_out_valid on the cycle SHIFT→WAIT transition edge counts as SHIFT, so it flags an error.
- Arithmetic: counter is unsigned cntWidth and never wraps (exits SHIFT at numInputs-1). No data arithmetic; words pass through bit-exact.

Decomposition:
- Shared package nn_pkg holds:
  - the state enum seq_state_t {IDLE, SHIFT, WAIT} (2-bit);
  - the default constants DATA_WIDTH=16, HIDDEN_NEURONS=30, OUTPUT_NEURONS=10.
- No sub-module: a single module holding the FSM, counter, buffer and word mux is natural.
- The top level instantiates one layer_sequencer per layer boundary.

Test Plan (numInputs=4, dataWidth=16 unless noted):
1. Reset mid-SHIFT: accept frame {0x0004,0x0003,0x0002,0x0001}, assert rst_n=0 after 2 beats -> layer_in_valid=0, layer_in_data=0 and frame_in_ready=0 immediately during reset; after release, frame_in_ready=1, busy=0, no further beats.
2. Basic frame: frame_in_data words 0..3 = 0x0011,0x0022,0x0033,0x0044 accepted at T -> layer_in_valid=1 on T+1..T+4 with exactly 0x0011,0x0022,0x0033,0x0044; 0 at T+5; frame_in_ready=0 from T+1.
3. Result wait: after test 2, drive layer_out_valid 7 cycles after last beat -> frame_done single pulse next cycle; frame_in_ready=1 that same cycle; proto_err=0.
4. Backpressure: hold frame_in_valid=1 with new vector 0xAAAA.. continuously through SHIFT/WAIT -> no capture until IDLE; second frame's first beat starts the cycle after the frame_done cycle's accept edge, with its 4 beats contiguous.
5. Protocol error: pulse layer_out_valid during beat 2 of SHIFT -> proto_err=1 sticky, beats continue unchanged, no frame_done until a real pulse in WAIT.
6. numInputs=1, dataWidth=16: frame 0xBEEF -> exactly one beat 0xBEEF at T+1, WAIT at T+2; layer_out_valid -> frame_done.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and default sizes for the layer pipeline
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    localparam int DATA_WIDTH     = 16;
    localparam int HIDDEN_NEURONS = 30;
    localparam int OUTPUT_NEURONS = 10;

endpackage

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - accepts one activation vector, streams it word by word
// into a layer, then waits for the layer result before taking the next frame
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int numInputs = HIDDEN_NEURONS,
    parameter int dataWidth = DATA_WIDTH,
    parameter int cntWidth  = $clog2(numInputs + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           frame_in_valid,
    input  logic [numInputs*dataWidth-1:0] frame_in_data,
    output logic                           frame_in_ready,
    output logic                           layer_in_valid,
    output logic [dataWidth-1:0]           layer_in_data,
    input  logic                           layer_out_valid,
    output logic                           frame_done,
    output logic                           busy,
    output logic                           proto_err
);

    localparam int BufWidth = numInputs * dataWidth;

    seq_state_t          state;
    seq_state_t          state_next;
    logic [cntWidth-1:0] beat_cnt;
    logic [BufWidth-1:0] vec_buf;
    logic [BufWidth-1:0] vec_shifted;
    logic                last_beat;

    // The buffer shifts down one word per beat, so word 0 is always the current beat.
    assign vec_shifted    = vec_buf >> dataWidth;
    assign last_beat      = (beat_cnt == cntWidth'(numInputs - 1));
    assign frame_in_ready = rst_n && (state == IDLE);
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_in_valid)  state_next = SHIFT;
            SHIFT:   if (last_beat)       state_next = WAIT;
            WAIT:    if (layer_out_valid) state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt       <= '0;
            vec_buf        <= '0;
            layer_in_valid <= 1'b0;
            layer_in_data  <= '0;
            frame_done     <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // A result arriving outside WAIT cannot belong to a completed frame.
            if (layer_out_valid && (state != WAIT)) begin
                proto_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_in_valid) begin
                        vec_buf        <= frame_in_data;
                        beat_cnt       <= '0;
                        layer_in_valid <= 1'b1;
                        layer_in_data  <= frame_in_data[dataWidth-1:0];
                    end
                end
                SHIFT: begin
                    if (last_beat) begin
                        layer_in_valid <= 1'b0;
                    end else begin
                        beat_cnt      <= beat_cnt + cntWidth'(1);
                        vec_buf       <= vec_shifted;
                        layer_in_data <= vec_shifted[dataWidth-1:0];
                    end
                end
                WAIT: begin
                    if (layer_out_valid) begin
                        frame_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - directed checks of layer_sequencer at fan-in 4 and 1
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_fiv;
    logic [63:0] a_fid;
    logic        a_fir, a_liv, a_lov, a_done, a_busy, a_err;
    logic [15:0] a_lid;

    logic        b_fiv;
    logic [15:0] b_fid;
    logic        b_fir, b_liv, b_lov, b_done, b_busy, b_err;
    logic [15:0] b_lid;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    layer_sequencer #(.numInputs(4), .dataWidth(16)) u_seq4 (
        .clk(clk), .rst_n(rst_n),
        .frame_in_valid(a_fiv), .frame_in_data(a_fid), .frame_in_ready(a_fir),
        .layer_in_valid(a_liv), .layer_in_data(a_lid), .layer_out_valid(a_lov),
        .frame_done(a_done), .busy(a_busy), .proto_err(a_err)
    );

    layer_sequencer #(.numInputs(1), .dataWidth(16)) u_seq1 (
        .clk(clk), .rst_n(rst_n),
        .frame_in_valid(b_fiv), .frame_in_data(b_fid), .frame_in_ready(b_fir),
        .layer_in_valid(b_liv), .layer_in_data(b_lid), .layer_out_valid(b_lov),
        .frame_done(b_done), .busy(b_busy), .proto_err(b_err)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] words [4];

    initial begin
        rst_n = 1'b0;
        a_fiv = 1'b0; a_fid = '0; a_lov = 1'b0;
        b_fiv = 1'b0; b_fid = '0; b_lov = 1'b0;
        tick();
        tick();
        check_vec("rst_ready", 32'(a_fir), 32'd0);
        check_vec("rst_liv", 32'(a_liv), 32'd0);
        rst_n = 1'b1;
        #1;
        check_vec("idle_ready", 32'(a_fir), 32'd1);
        check_vec("idle_busy", 32'(a_busy), 32'd0);
        check_vec("idle_err", 32'(a_err), 32'd0);

        // 1: reset in the middle of SHIFT
        a_fid = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        a_fiv = 1'b1;
        tick();
        a_fiv = 1'b0;
        check_vec("t1_beat0", {15'd0, a_liv, a_lid}, {15'd0, 1'b1, 16'h0001});
        tick();
        check_vec("t1_beat1", {15'd0, a_liv, a_lid}, {15'd0, 1'b1, 16'h0002});
        rst_n = 1'b0;
        #1;
        check_vec("t1_rst_liv", 32'(a_liv), 32'd0);
        check_vec("t1_rst_lid", 32'(a_lid), 32'd0);
        check_vec("t1_rst_ready", 32'(a_fir), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check_vec("t1_rel_ready", 32'(a_fir), 32'd1);
        check_vec("t1_rel_busy", 32'(a_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("t1_no_beats", 32'(a_liv), 32'd0);
        end

        // 2: basic frame
        words = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        a_fid = {words[3], words[2], words[1], words[0]};
        a_fiv = 1'b1;
        tick();
        a_fiv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_vec("t2_beat", {15'd0, a_liv, a_lid}, {15'd0, 1'b1, words[k]});
            check_vec("t2_ready", 32'(a_fir), 32'd0);
            tick();
        end
        check_vec("t2_liv_after", 32'(a_liv), 32'd0);
        check_vec("t2_lid_hold", 32'(a_lid), 32'h0044);
        check_vec("t2_busy", 32'(a_busy), 32'd1);

        // 3: result arrives 7 cycles after the last beat
        for (int i = 0; i < 6; i++) begin
            tick();
            check_vec("t3_no_done", 32'(a_done), 32'd0);
        end
        a_lov = 1'b1;
        tick();
        a_lov = 1'b0;
        check_vec("t3_done", 32'(a_done), 32'd1);
        check_vec("t3_ready", 32'(a_fir), 32'd1);
        check_vec("t3_err", 32'(a_err), 32'd0);
        tick();
        check_vec("t3_done_pulse", 32'(a_done), 32'd0);

        // 4: upstream holds valid through the whole frame
        words = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        a_fid = {words[3], words[2], words[1], words[0]};
        a_fiv = 1'b1;
        tick();
        a_fid = {16'hAAA3, 16'hAAA2, 16'hAAA1, 16'hAAA0};
        for (int k = 0; k < 4; k++) begin
            check_vec("t4_beat_a", {15'd0, a_liv, a_lid}, {15'd0, 1'b1, words[k]});
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check_vec("t4_wait_ready", {30'd0, a_fir, a_liv}, 32'd0);
            tick();
        end
        a_lov = 1'b1;
        tick();
        a_lov = 1'b0;
        check_vec("t4_done", {30'd0, a_done, a_fir}, 32'd3);
        tick();
        a_fiv = 1'b0;
        words = '{16'hAAA0, 16'hAAA1, 16'hAAA2, 16'hAAA3};
        for (int k = 0; k < 4; k++) begin
            check_vec("t4_beat_b", {15'd0, a_liv, a_lid}, {15'd0, 1'b1, words[k]});
            tick();
        end
        check_vec("t4_b_end", 32'(a_liv), 32'd0);
        a_lov = 1'b1;
        tick();
        a_lov = 1'b0;
        check_vec("t4_b_done", 32'(a_done), 32'd1);
        tick();

        // 5: stray result during SHIFT
        words = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        a_fid = {words[3], words[2], words[1], words[0]};
        a_fiv = 1'b1;
        tick();
        a_fiv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_vec("t5_beat", {15'd0, a_liv, a_lid}, {15'd0, 1'b1, words[k]});
            check_vec("t5_no_done", 32'(a_done), 32'd0);
            a_lov = (k == 1);
            tick();
            a_lov = 1'b0;
        end
        check_vec("t5_err", 32'(a_err), 32'd1);
        check_vec("t5_wait", {29'd0, a_liv, a_done, a_busy}, 32'd1);
        tick();
        check_vec("t5_still_wait", {30'd0, a_done, a_busy}, 32'd1);
        a_lov = 1'b1;
        tick();
        a_lov = 1'b0;
        check_vec("t5_done", 32'(a_done), 32'd1);
        check_vec("t5_err_sticky", 32'(a_err), 32'd1);

        // 6: single-word frames
        b_fid = 16'hBEEF;
        b_fiv = 1'b1;
        tick();
        b_fiv = 1'b0;
        check_vec("t6_beat", {15'd0, b_liv, b_lid}, {15'd0, 1'b1, 16'hBEEF});
        tick();
        check_vec("t6_wait", {29'd0, b_liv, b_busy, b_fir}, 32'd2);
        tick();
        check_vec("t6_hold", {30'd0, b_liv, b_done}, 32'd0);
        b_lov = 1'b1;
        tick();
        b_lov = 1'b0;
        check_vec("t6_done", {29'd0, b_done, b_fir, b_err}, 32'd6);
        tick();
        check_vec("t6_done_pulse", 32'(b_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
